// File: rtl/dft_frame_feeder.sv
// dft_frame_feeder
//   Assembles an upstream stream of WIDTH-bit samples into frames of
//   LANES*FRAME_CYCLES words in a two-bank (ping-pong) buffer, then plays each
//   full frame to the DFT core: a one-cycle `next` pulse followed by
//   FRAME_CYCLES back-to-back cycles of LANES words on X0..X3. Successive
//   `next` pulses are kept at least MIN_GAP clk cycles apart.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   s_data       upstream sample word
//   s_valid      s_data valid
//   s_ready      feeder accepts a word this cycle (registered)
//   flush        (DFT_FEEDER_FLUSH_EN only) discard the partially filled bank
//   next         one-cycle frame-start pulse to the core
//   X0..X3       core input lanes (registered)
//   busy         high from `next` through the last stream cycle
//   frames_sent  count of frames fully streamed, wraps
//
// Configuration
//   DFT_FEEDER_FLUSH_EN  when defined, adds the `flush` input.
module dft_frame_feeder #(
    parameter int WIDTH        = 16,
    parameter int LANES        = 4,
    parameter int FRAME_CYCLES = 512,
    parameter int MIN_GAP      = 5141
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
`ifdef DFT_FEEDER_FLUSH_EN
    input  logic             flush,
`endif
    output logic             s_ready,
    output logic             next,
    output logic [WIDTH-1:0] X0,
    output logic [WIDTH-1:0] X1,
    output logic [WIDTH-1:0] X2,
    output logic [WIDTH-1:0] X3,
    output logic             busy,
    output logic [15:0]      frames_sent
);

    localparam int WORDS  = LANES * FRAME_CYCLES;
    localparam int PTR_W  = $clog2(WORDS);
    localparam int ROW_W  = $clog2(FRAME_CYCLES);
    localparam int LANE_W = $clog2(LANES);
    localparam int GAP_W  = $clog2(MIN_GAP);

    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(MIN_GAP - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_W   = PTR_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, NEXT, STREAM} state_t;

    // Bank b, row r lives at index {b, r}; one column per lane.
    logic [WIDTH-1:0] mem [2*FRAME_CYCLES][LANES];

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic                         fill_bank_q, fill_bank_d;
    logic                         st_bank_q, st_bank_d;
    logic [1:0]                   full_q, full_d;
    logic                         s_ready_q, s_ready_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [GAP_W-1:0]             gap_q, gap_d;
    logic [15:0]                  frames_q, frames_d;
    logic [LANES-1:0][WIDTH-1:0]  x_q, x_d;

    logic             flush_w;
    logic             wr_en;
    logic             stream_done;
    logic [ROW_W-1:0] rd_row;

`ifdef DFT_FEEDER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A flush cycle refuses data so the discarded word is never acknowledged.
    assign s_ready     = s_ready_q & ~flush_w;
    assign wr_en       = s_valid & s_ready;
    assign stream_done = (state_q == STREAM) && (row_q == LAST_ROW);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_bank_q <= 1'b0;
            st_bank_q   <= 1'b0;
            full_q      <= '0;
            s_ready_q   <= 1'b0;
            row_q       <= '0;
            gap_q       <= GAP_SAT;   // first frame is never gap-limited
            frames_q    <= '0;
            x_q         <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_bank_q <= fill_bank_d;
            st_bank_q   <= st_bank_d;
            full_q      <= full_d;
            s_ready_q   <= s_ready_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
            frames_q    <= frames_d;
            x_q         <= x_d;
        end
    end

    // Buffer storage carries no reset; the full flags say what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{fill_bank_q, wr_ptr_q[PTR_W-1:LANE_W]}][wr_ptr_q[LANE_W-1:0]] <= s_data;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[st_bank_q] && (gap_q >= GAP_SAT)) state_d = NEXT;
            NEXT:    state_d = STREAM;
            STREAM:  if (row_q == LAST_ROW) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- fill side ----------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_bank_d = fill_bank_q;
        full_d      = full_q;
        if (flush_w) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            if (wr_ptr_q == LAST_W) begin
                wr_ptr_d            = '0;
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        // Fill never targets the streaming bank, so this cannot collide with
        // the set above.
        if (stream_done)
            full_d[st_bank_q] = 1'b0;
        // Registered ready: computed from next-cycle occupancy.
        s_ready_d = ~full_d[fill_bank_d];
    end

    // ---------------- stream side ----------------
    always_comb begin
        row_d     = '0;
        st_bank_d = st_bank_q;
        frames_d  = frames_q;
        gap_d     = gap_q;
        x_d       = '0;

        // Gap is 0 during the NEXT cycle so the following `next` lands exactly
        // MIN_GAP cycles later.
        if (state_q == IDLE && state_d == NEXT)
            gap_d = '0;
        else if (gap_q != GAP_SAT)
            gap_d = gap_q + 1'b1;

        if (state_q == STREAM)
            row_d = row_q + 1'b1;

        // Read one row ahead so X holds row r during stream cycle r.
        rd_row = (state_q == NEXT) ? '0 : row_q + 1'b1;
        if (state_q == NEXT || (state_q == STREAM && row_q != LAST_ROW)) begin
            for (int l = 0; l < LANES; l++)
                x_d[l] = mem[{st_bank_q, rd_row}][l];
        end

        if (stream_done) begin
            st_bank_d = ~st_bank_q;
            frames_d  = frames_q + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        next        = (state_q == NEXT);
        busy        = (state_q != IDLE);
        frames_sent = frames_q;
        X0          = x_q[0];
        X1          = x_q[1];
        X2          = x_q[2];
        X3          = x_q[3];
    end

endmodule

// File: tb/tb_dft_frame_feeder.sv
module tb_dft_frame_feeder;

    logic        clk;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        next;
    logic [15:0] X0, X1, X2, X3;
    logic        busy;
    logic [15:0] frames_sent;
`ifdef DFT_FEEDER_FLUSH_EN
    logic        flush;
`endif

    dft_frame_feeder dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
`ifdef DFT_FEEDER_FLUSH_EN
        .flush(flush),
`endif
        .s_ready(s_ready), .next(next), .X0(X0), .X1(X1), .X2(X2), .X3(X3),
        .busy(busy), .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor: records frames seen on the core side ----------------
    int          cyc;
    int          n_next;
    int          n_frames;
    int          cap_row;
    int          stall_cnt;
    bit          post_pending;
    int          next_cyc [8];
    logic [15:0] cap [8][2048];
    bit          busy_bad [8];
    logic [63:0] post_x [8];
    logic        post_busy [8];
    logic [15:0] post_fs [8];

    initial begin
        cyc = 0; n_next = 0; n_frames = 0; cap_row = -1; stall_cnt = 0; post_pending = 0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            n_next = 0; n_frames = 0; cap_row = -1; stall_cnt = 0; post_pending = 0;
        end else begin
            if (s_valid && !s_ready) stall_cnt++;
            if (post_pending && n_frames > 0 && n_frames <= 8) begin
                post_x[n_frames-1]    = {X3, X2, X1, X0};
                post_busy[n_frames-1] = busy;
                post_fs[n_frames-1]   = frames_sent;
                post_pending = 0;
            end
            if (cap_row >= 0 && n_frames < 8) begin
                cap[n_frames][cap_row*4+0] = X0;
                cap[n_frames][cap_row*4+1] = X1;
                cap[n_frames][cap_row*4+2] = X2;
                cap[n_frames][cap_row*4+3] = X3;
                if (!busy || next) busy_bad[n_frames] = 1;
                if (cap_row == 511) begin
                    cap_row = -1; n_frames++; post_pending = 1;
                end else cap_row++;
            end
            if (next && n_next < 8) begin
                next_cyc[n_next] = cyc;
                n_next++;
                cap_row = 0;
                if (n_frames < 8) busy_bad[n_frames] = !busy;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          test;
        int          frame;
        int          row;
        logic [15:0] x0, x1, x2, x3;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_frame(input string name, input int f, input int base);
        int bad;
        logic [15:0] expw;
        bad = -1;
        for (int i = 0; i < 2048; i++) begin
            expw = 16'(base + i);
            if (bad < 0 && cap[f][i] !== expw) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            expw = 16'(base + bad);
            $display("FAIL %s data: word %0d got %0d expected %0d", name, bad, cap[f][bad], expw);
        end
        chk({name, " busy_during_stream_ok"}, {63'd0, busy_bad[f]}, 64'd0);
        chk({name, " x_after_stream"}, post_x[f], 64'd0);
        chk({name, " busy_after_stream"}, {63'd0, post_busy[f]}, 64'd0);
        chk({name, " frames_sent"}, {48'd0, post_fs[f]}, 64'(f + 1));
    endtask

    task automatic apply_table(input int id);
        for (int k = 0; k < 12; k++) begin
            if (vecs[k].test == id) begin
                chk($sformatf("t%0d f%0d row%0d", id, vecs[k].frame, vecs[k].row),
                    {cap[vecs[k].frame][vecs[k].row*4+3], cap[vecs[k].frame][vecs[k].row*4+2],
                     cap[vecs[k].frame][vecs[k].row*4+1], cap[vecs[k].frame][vecs[k].row*4+0]},
                    {vecs[k].x3, vecs[k].x2, vecs[k].x1, vecs[k].x0});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Push n ramp words starting at base; bursty toggles s_valid every cycle.
    task automatic push(input int base, input int n, input bit bursty, input int budget);
        int i, t;
        bit ph, acc;
        i = 0; t = 0; ph = 1'b1;
        while (i < n && t < budget) begin
            s_valid = bursty ? ph : 1'b1;
            s_data  = 16'(base + i);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            ph = ~ph;
            t++;
        end
        s_valid = 1'b0;
        chk($sformatf("push base %0d words accepted", base), 64'(i), 64'(n));
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (n_frames < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        chk($sformatf("frames completed (want %0d)", n), 64'(n_frames), 64'(n));
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0,   16'd0,    16'd1,    16'd2,    16'd3};
        vecs[1]  = '{1, 0, 1,   16'd4,    16'd5,    16'd6,    16'd7};
        vecs[2]  = '{1, 0, 511, 16'd2044, 16'd2045, 16'd2046, 16'd2047};
        vecs[3]  = '{2, 1, 0,   16'd2048, 16'd2049, 16'd2050, 16'd2051};
        vecs[4]  = '{2, 1, 511, 16'd4092, 16'd4093, 16'd4094, 16'd4095};
        vecs[5]  = '{2, 2, 255, 16'd5116, 16'd5117, 16'd5118, 16'd5119};
        vecs[6]  = '{3, 0, 300, 16'd1200, 16'd1201, 16'd1202, 16'd1203};
        vecs[7]  = '{3, 0, 511, 16'd2044, 16'd2045, 16'd2046, 16'd2047};
        vecs[8]  = '{4, 0, 0,   16'd9000, 16'd9001, 16'd9002, 16'd9003};
        vecs[9]  = '{4, 0, 127, 16'd9508, 16'd9509, 16'd9510, 16'd9511};
        vecs[10] = '{5, 0, 0,   16'd5000, 16'd5001, 16'd5002, 16'd5003};
        vecs[11] = '{5, 0, 1,   16'd5004, 16'd5005, 16'd5006, 16'd5007};

        reset = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef DFT_FEEDER_FLUSH_EN
        flush = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {next, busy, s_ready, frames_sent, X0, X1, X2, X3}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("s_ready after release", {63'd0, s_ready}, 64'd1);

        // ---- test 1: single ramp frame ----
        push(0, 2048, 1'b0, 3000);
        wait_frames(1, 2000);
        repeat (20) @(posedge clk);
        chk("t1 next count", 64'(n_next), 64'd1);
        check_frame("t1 frame0", 0, 0);
        apply_table(1);

        // ---- test 2: gap enforcement + backpressure ----
        do_reset();
        push(0, 6244, 1'b0, 20000);
        wait_frames(3, 12000);
        chk("t2 gap 0->1", 64'(next_cyc[1] - next_cyc[0]), 64'd5141);
        chk("t2 gap 1->2", 64'(next_cyc[2] - next_cyc[1]), 64'd5141);
        chk("t2 stalled while both banks full", {63'd0, stall_cnt > 0}, 64'd1);
        check_frame("t2 frame0", 0, 0);
        check_frame("t2 frame1", 1, 2048);
        check_frame("t2 frame2", 2, 4096);
        apply_table(2);

        // ---- test 3: bursty input ----
        do_reset();
        push(0, 2048, 1'b1, 5000);
        wait_frames(1, 2000);
        check_frame("t3 frame0", 0, 0);
        apply_table(3);

        // ---- test 4: reset mid-stream ----
        do_reset();
        push(300, 2048, 1'b0, 3000);
        begin
            int t;
            t = 0;
            while (n_next < 1 && t < 100) begin @(posedge clk); t++; end
        end
        chk("t4 first next seen", 64'(n_next), 64'd1);
        repeat (100) @(posedge clk);
        #1;
        chk("t4 busy before reset", {63'd0, busy}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("t4 outputs in reset", {next, busy, s_ready, frames_sent, X0, X1, X2, X3}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        chk("t4 no next after reset", 64'(n_next), 64'd0);
        chk("t4 frames_sent after reset", {48'd0, frames_sent}, 64'd0);
        push(9000, 2048, 1'b0, 3000);
        wait_frames(1, 2000);
        check_frame("t4 frame0", 0, 9000);
        apply_table(4);

`ifdef DFT_FEEDER_FLUSH_EN
        // ---- test 5: flush ----
        do_reset();
        push(100, 1000, 1'b0, 2000);
        flush = 1'b1; s_valid = 1'b1; s_data = 16'd77;
        #1;
        chk("t5 s_ready on flush", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; s_valid = 1'b0;
        push(5000, 2048, 1'b0, 3000);
        wait_frames(1, 2000);
        chk("t5 next count", 64'(n_next), 64'd1);
        check_frame("t5 frame0", 0, 5000);
        apply_table(5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
